// File: rtl/ap_ctrl_profiler.sv
// Purpose: drives an ap_ctrl_hs kernel through a batch of invocations and profiles latency and loop-iteration activity.
// Latency: every output is registered; cfg_start is acted on at the next edge, batch_done pulses the cycle after the batch ends.
// Backpressure: k_ap_start holds until k_ap_ready is seen; a kernel that never finishes is abandoned after TIMEOUT cycles.
module ap_ctrl_profiler #(
    parameter int CNT_W   = 32,
    parameter int RUNS_W  = 16,
    parameter int TIMEOUT = 1000000
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              cfg_start,
    input  logic [RUNS_W-1:0] cfg_runs,
    output logic              k_ap_start,
    input  logic              k_ap_ready,
    input  logic              k_ap_done,
    input  logic              iter_start,
    input  logic              iter_end,
    output logic              busy,
    output logic              batch_done,
    output logic [RUNS_W-1:0] run_count,
    output logic [CNT_W-1:0]  lat_min,
    output logic [CNT_W-1:0]  lat_max,
    output logic [CNT_W-1:0]  lat_total,
    output logic [CNT_W-1:0]  iter_starts,
    output logic [CNT_W-1:0]  iter_ends,
    output logic [CNT_W-1:0]  max_inflight,
    output logic              err_timeout,
    output logic              err_iter
);

    localparam logic [CNT_W-1:0]  ONES_C = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  ZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [RUNS_W-1:0] ZERO_R = {RUNS_W{1'b0}};
    localparam logic [RUNS_W-1:0] ONE_R  = {{(RUNS_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  TMO_C  = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_DONE,
        ST_FINISH
    } state_t;

    state_t            state_q;
    logic              k_start_q;
    logic              busy_q;
    logic              batch_done_q;
    logic [RUNS_W-1:0] runs_q;
    logic [RUNS_W-1:0] run_cnt_q;
    logic [CNT_W-1:0]  lat_cnt_q;
    logic [CNT_W-1:0]  lat_q;
    logic [CNT_W-1:0]  lat_min_q;
    logic [CNT_W-1:0]  lat_max_q;
    logic [CNT_W-1:0]  lat_tot_q;
    logic              err_to_q;

    logic [CNT_W-1:0]  starts_q;
    logic [CNT_W-1:0]  ends_q;
    logic [CNT_W-1:0]  infl_q;
    logic [CNT_W-1:0]  max_infl_q;
    logic              err_iter_q;

    logic [CNT_W:0]    tot_sum;
    logic [CNT_W-1:0]  lat_tot_d;
    logic              batch_clr;
    logic              end_ok;
    logic [CNT_W-1:0]  infl_d;
    logic [CNT_W-1:0]  starts_d;
    logic [CNT_W-1:0]  ends_d;

    // Saturating accumulators and in-flight bookkeeping for the next edge.
    always_comb begin
        tot_sum   = {1'b0, lat_tot_q} + {1'b0, lat_q};
        lat_tot_d = tot_sum[CNT_W] ? ONES_C : tot_sum[CNT_W-1:0];
        batch_clr = (state_q == ST_IDLE) && cfg_start;
        // An end strobe with nothing in flight is a protocol error and is not counted.
        end_ok    = iter_end && (infl_q != ZERO_C);
        infl_d    = infl_q + CNT_W'(iter_start) - CNT_W'(end_ok);
        starts_d  = (starts_q == ONES_C) ? ONES_C : starts_q + ONE_C;
        ends_d    = (ends_q == ONES_C) ? ONES_C : ends_q + ONE_C;
    end

    // Batch sequencer: launch, wait for done or timeout, fold each latency into the statistics.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= ST_IDLE;
            k_start_q    <= 1'b0;
            busy_q       <= 1'b0;
            batch_done_q <= 1'b0;
            runs_q       <= ZERO_R;
            run_cnt_q    <= ZERO_R;
            lat_cnt_q    <= ZERO_C;
            lat_q        <= ZERO_C;
            lat_min_q    <= ONES_C;
            lat_max_q    <= ZERO_C;
            lat_tot_q    <= ZERO_C;
            err_to_q     <= 1'b0;
        end else begin
            batch_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cfg_start) begin
                        runs_q    <= cfg_runs;
                        run_cnt_q <= ZERO_R;
                        lat_min_q <= ONES_C;
                        lat_max_q <= ZERO_C;
                        lat_tot_q <= ZERO_C;
                        err_to_q  <= 1'b0;
                        if (cfg_runs != ZERO_R) begin
                            state_q   <= ST_LAUNCH;
                            busy_q    <= 1'b1;
                            k_start_q <= 1'b1;
                            lat_cnt_q <= ONE_C;
                        end else begin
                            batch_done_q <= 1'b1;
                        end
                    end
                end
                ST_LAUNCH, ST_WAIT_DONE: begin
                    if (k_ap_done) begin
                        lat_q     <= lat_cnt_q;
                        k_start_q <= 1'b0;
                        state_q   <= ST_FINISH;
                    end else if (lat_cnt_q == TMO_C) begin
                        err_to_q     <= 1'b1;
                        k_start_q    <= 1'b0;
                        busy_q       <= 1'b0;
                        batch_done_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + ONE_C;
                        if ((state_q == ST_LAUNCH) && k_ap_ready) begin
                            k_start_q <= 1'b0;
                            state_q   <= ST_WAIT_DONE;
                        end
                    end
                end
                ST_FINISH: begin
                    lat_min_q <= (lat_q < lat_min_q) ? lat_q : lat_min_q;
                    lat_max_q <= (lat_q > lat_max_q) ? lat_q : lat_max_q;
                    lat_tot_q <= lat_tot_d;
                    run_cnt_q <= run_cnt_q + ONE_R;
                    if ((run_cnt_q + ONE_R) < runs_q) begin
                        state_q   <= ST_LAUNCH;
                        k_start_q <= 1'b1;
                        lat_cnt_q <= ONE_C;
                    end else begin
                        state_q      <= ST_IDLE;
                        busy_q       <= 1'b0;
                        batch_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Iteration strobe counters, live only while a batch is running.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            starts_q   <= ZERO_C;
            ends_q     <= ZERO_C;
            infl_q     <= ZERO_C;
            max_infl_q <= ZERO_C;
            err_iter_q <= 1'b0;
        end else if (batch_clr) begin
            starts_q   <= ZERO_C;
            ends_q     <= ZERO_C;
            infl_q     <= ZERO_C;
            max_infl_q <= ZERO_C;
            err_iter_q <= 1'b0;
        end else if (busy_q) begin
            if (iter_start) begin
                starts_q <= starts_d;
            end
            if (end_ok) begin
                ends_q <= ends_d;
            end
            if (iter_end && !end_ok) begin
                err_iter_q <= 1'b1;
            end
            infl_q <= infl_d;
            if (infl_d > max_infl_q) begin
                max_infl_q <= infl_d;
            end
        end
    end

    assign k_ap_start   = k_start_q;
    assign busy         = busy_q;
    assign batch_done   = batch_done_q;
    assign run_count    = run_cnt_q;
    assign lat_min      = lat_min_q;
    assign lat_max      = lat_max_q;
    assign lat_total    = lat_tot_q;
    assign iter_starts  = starts_q;
    assign iter_ends    = ends_q;
    assign max_inflight = max_infl_q;
    assign err_timeout  = err_to_q;
    assign err_iter     = err_iter_q;

endmodule

// File: tb/tb_ap_ctrl_profiler.sv
// Purpose: randomized and directed batches against a cycle-stepped kernel/statistics model.
// Latency: inputs change 1ns after the rising edge, outputs are checked at that same point before new inputs apply.
// Backpressure: the bench plays the kernel, choosing ready and done cycles per invocation.
module tb_ap_ctrl_profiler;

    localparam int TMO = 20;
    localparam longint ONES = 64'h0000_0000_FFFF_FFFF;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic [15:0] cfg_runs = '0;
    logic        k_ap_start;
    logic        k_ap_ready = 1'b0;
    logic        k_ap_done = 1'b0;
    logic        iter_start = 1'b0;
    logic        iter_end = 1'b0;
    logic        busy;
    logic        batch_done;
    logic [15:0] run_count;
    logic [31:0] lat_min, lat_max, lat_total;
    logic [31:0] iter_starts, iter_ends, max_inflight;
    logic        err_timeout, err_iter;

    ap_ctrl_profiler #(.CNT_W(32), .RUNS_W(16), .TIMEOUT(TMO)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .cfg_start(cfg_start), .cfg_runs(cfg_runs),
        .k_ap_start(k_ap_start), .k_ap_ready(k_ap_ready), .k_ap_done(k_ap_done),
        .iter_start(iter_start), .iter_end(iter_end), .busy(busy), .batch_done(batch_done),
        .run_count(run_count), .lat_min(lat_min), .lat_max(lat_max), .lat_total(lat_total),
        .iter_starts(iter_starts), .iter_ends(iter_ends), .max_inflight(max_inflight),
        .err_timeout(err_timeout), .err_iter(err_iter)
    );

    always #5 ap_clk = ~ap_clk;

    int nvec = 0;
    int nerr = 0;
    int bno = 0;

    // Reference model state
    longint m_runs, m_min, m_max, m_total;
    longint m_starts, m_ends, m_infl, m_maxinf;
    bit     m_err_iter, m_err_to;
    int     plan_r[8];
    int     plan_l[8];
    int     iter_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL batch %0d %s: got %0d expected %0d", bno, tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_runs = 0; m_min = ONES; m_max = 0; m_total = 0;
        m_starts = 0; m_ends = 0; m_infl = 0; m_maxinf = 0;
        m_err_iter = 0; m_err_to = 0;
    endtask

    task automatic check_stats();
        check("run_count", run_count, m_runs);
        check("lat_min", lat_min, m_min);
        check("lat_max", lat_max, m_max);
        check("lat_total", lat_total, m_total);
        check("iter_starts", iter_starts, m_starts);
        check("iter_ends", iter_ends, m_ends);
        check("max_inflight", max_inflight, m_maxinf);
        check("err_iter", err_iter, m_err_iter);
        check("err_timeout", err_timeout, m_err_to);
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
        cfg_start = 1'b0; k_ap_ready = 1'b0; k_ap_done = 1'b0;
        iter_start = 1'b0; iter_end = 1'b0;
    endtask

    // Drive this cycle's loop strobes; when the block is busy, apply the counting rules to the model.
    task automatic drive_strobes(input bit counted);
        int v;
        longint old;
        if (counted && iter_q.size() > 0) v = iter_q.pop_front();
        else v = int'($urandom_range(0, 3));
        iter_start = v[0];
        iter_end   = v[1];
        if (counted) begin
            cfg_start = ($urandom_range(0, 7) == 0);
            cfg_runs  = 16'($urandom);
            old = m_infl;
            if (v[0]) begin
                m_starts = (m_starts + 1 > ONES) ? ONES : m_starts + 1;
                m_infl++;
            end
            if (v[1]) begin
                if (old == 0) m_err_iter = 1;
                else begin
                    m_ends = (m_ends + 1 > ONES) ? ONES : m_ends + 1;
                    m_infl--;
                end
            end
            if (m_infl > m_maxinf) m_maxinf = m_infl;
        end
    endtask

    // One batch of n invocations following plan_r/plan_l; optionally reset at (rst_inv, rst_cyc).
    task automatic run_batch(input int n, input int rst_inv, input int rst_cyc);
        bit to;
        int lat;
        bno++;
        drive_strobes(0);
        cfg_start = 1'b1;
        cfg_runs  = 16'(n);
        tick();
        model_clear();
        if (n == 0) begin
            check("zero_batch_done", batch_done, 1);
            check("zero_k_start", k_ap_start, 0);
            check("zero_busy", busy, 0);
            check_stats();
            drive_strobes(0);
            tick();
            check("zero_batch_done_end", batch_done, 0);
            check("zero_k_start_end", k_ap_start, 0);
            check_stats();
            return;
        end
        to = 0;
        for (int i = 0; i < n && !to; i++) begin
            for (int c = 1; c <= TMO; c++) begin
                check("k_ap_start", k_ap_start, (c <= plan_r[i]) ? 1 : 0);
                check("busy", busy, 1);
                check("batch_done_mid", batch_done, 0);
                k_ap_ready = (c == plan_r[i]);
                k_ap_done  = (c == plan_l[i]);
                drive_strobes(1);
                if (i == rst_inv && c == rst_cyc) begin
                    #2 ap_rst_n = 1'b0;
                    #1;
                    model_clear();
                    check("rst_k_start", k_ap_start, 0);
                    check("rst_busy", busy, 0);
                    check("rst_batch_done", batch_done, 0);
                    check_stats();
                    cfg_start = 1'b0; k_ap_ready = 1'b0; k_ap_done = 1'b0;
                    iter_start = 1'b0; iter_end = 1'b0;
                    @(posedge ap_clk);
                    #1;
                    check("rst_hold_busy", busy, 0);
                    check_stats();
                    @(posedge ap_clk);
                    #1;
                    ap_rst_n = 1'b1;
                    return;
                end
                tick();
                if (c == plan_l[i]) break;
                if (c == TMO) to = 1;
            end
            if (!to) begin
                lat = plan_l[i];
                check("finish_k_start", k_ap_start, 0);
                check("finish_busy", busy, 1);
                drive_strobes(1);
                m_runs++;
                if (lat < m_min) m_min = lat;
                if (lat > m_max) m_max = lat;
                m_total = (m_total + lat > ONES) ? ONES : m_total + lat;
                tick();
            end
        end
        if (to) m_err_to = 1;
        check("end_batch_done", batch_done, 1);
        check("end_busy", busy, 0);
        check("end_k_start", k_ap_start, 0);
        check_stats();
        drive_strobes(0);
        tick();
        check("idle_batch_done", batch_done, 0);
        check("idle_busy", busy, 0);
        check_stats();
    endtask

    task automatic random_plan(input int n);
        for (int i = 0; i < n; i++) begin
            plan_r[i] = int'($urandom_range(1, 4));
            plan_l[i] = int'($urandom_range(plan_r[i], 24));
        end
    endtask

    initial begin
        model_clear();
        repeat (3) @(posedge ap_clk);
        #1;
        check("reset_k_start", k_ap_start, 0);
        check("reset_busy", busy, 0);
        check("reset_batch_done", batch_done, 0);
        check_stats();
        ap_rst_n = 1'b1;

        // Three runs, ready after 2 cycles, latencies 10/7/12
        for (int i = 0; i < 3; i++) plan_r[i] = 2;
        plan_l[0] = 10; plan_l[1] = 7; plan_l[2] = 12;
        run_batch(3, -1, 0);
        check("b1_lat_min", lat_min, 7);
        check("b1_lat_max", lat_max, 12);
        check("b1_lat_total", lat_total, 29);
        check("b1_run_count", run_count, 3);

        // Ready and done together in the first launch cycle
        plan_r[0] = 1; plan_l[0] = 1;
        run_batch(1, -1, 0);
        check("b2_lat_min", lat_min, 1);

        // Zero-run batch
        run_batch(0, -1, 0);
        check("b3_lat_min", lat_min, ONES);

        // Kernel never completes
        plan_r[0] = 2; plan_l[0] = 30; plan_r[1] = 2; plan_l[1] = 30;
        run_batch(2, -1, 0);
        check("b4_err_timeout", err_timeout, 1);
        check("b4_run_count", run_count, 0);

        // Iteration strobe sequence: 5 starts, a start/end pair, 7 ends, then quiet
        iter_q.delete();
        for (int i = 0; i < 5; i++) iter_q.push_back(1);
        iter_q.push_back(3);
        for (int i = 0; i < 7; i++) iter_q.push_back(2);
        iter_q.push_back(0);
        plan_r[0] = 1; plan_l[0] = 13;
        run_batch(1, -1, 0);
        check("b5_iter_starts", iter_starts, 6);
        check("b5_iter_ends", iter_ends, 6);
        check("b5_max_inflight", max_inflight, 5);
        check("b5_err_iter", err_iter, 1);
        iter_q.delete();

        // Reset in WAIT_DONE of the second of four runs, then a fresh batch
        for (int i = 0; i < 4; i++) begin plan_r[i] = 2; plan_l[i] = 6; end
        run_batch(4, 1, 4);
        random_plan(2);
        run_batch(2, -1, 0);

        // Randomized batches
        for (int b = 0; b < 12; b++) begin
            int n;
            n = int'($urandom_range(0, 4));
            random_plan(n);
            run_batch(n, -1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ap_ctrl_profiler.md
AP_CTRL_PROFILER -- requirements
Module: ap_ctrl_profiler

Interface
REQ-001 Parameter CNT_W, default 32, sets the width of the statistics and latency counters.
REQ-002 Parameter RUNS_W, default 16, sets the width of the invocation-count fields.
REQ-003 Parameter TIMEOUT, default 1000000, is the per-invocation cycle limit.
REQ-004 ap_clk  in  1  the single clock; all logic is on its rising edge.
REQ-005 ap_rst_n  in  1  reset, asynchronous and active-low.
REQ-006 cfg_start  in  1  single-cycle pulse that begins a batch.
REQ-007 cfg_runs  in  RUNS_W  number of kernel invocations in the batch; sampled on cfg_start.
REQ-008 k_ap_start  out  1  drives the kernel's ap_start (ap_ctrl_hs).
REQ-009 k_ap_ready  in  1  kernel ap_ready.
REQ-010 k_ap_done  in  1  kernel ap_done.
REQ-011 iter_start  in  1  pipelined-loop iteration-start strobe (stage0 state, iter0 enable, not blocked).
REQ-012 iter_end  in  1  pipelined-loop iteration-end strobe (last iteration enable, not blocked).
REQ-013 busy  out  1  high while a batch is active.
REQ-014 batch_done  out  1  one-cycle pulse at batch end (normal, zero-run, or abort).
REQ-015 run_count  out  RUNS_W  number of invocations completed in the current or last batch.
REQ-016 lat_min, lat_max, lat_total  out  CNT_W  latency statistics in cycles.
REQ-017 iter_starts, iter_ends  out  CNT_W  iteration strobe totals.
REQ-018 max_inflight  out  CNT_W  peak value of (iter_starts - iter_ends).
REQ-019 err_timeout, err_iter  out  1  sticky error flags.

Function
REQ-020 The FSM SHALL have the states IDLE, LAUNCH, WAIT_DONE and FINISH.
REQ-021 In IDLE, cfg_start with cfg_runs>0 SHALL clear all statistics, set lat_min to all-ones, clear the errors and enter LAUNCH next cycle.
REQ-022 In IDLE, cfg_start with cfg_runs==0 SHALL clear the statistics, pulse batch_done the next cycle and remain in IDLE.
REQ-023 cfg_start while busy SHALL be ignored.
REQ-024 In LAUNCH, k_ap_start SHALL be 1 and stay 1 until k_ap_ready is sampled 1; k_ap_start SHALL deassert the cycle after.
REQ-025 On LAUNCH entry, the latency counter SHALL load 1, then increment once per cycle in LAUNCH and WAIT_DONE.
REQ-026 On k_ap_done==1 (in LAUNCH or WAIT_DONE), latency SHALL equal the counter value in that cycle, and the state SHALL go to FINISH.
REQ-027 LAUNCH with k_ap_ready==1 and k_ap_done==0 SHALL go to WAIT_DONE.
REQ-028 When ready and done occur together, the block SHALL go straight to FINISH; the minimum latency is 1.
REQ-029 FINISH (one cycle) SHALL update lat_min = min, lat_max = max and lat_total += latency, and increment run_count.
REQ-030 FINISH SHALL then go to LAUNCH if run_count < cfg_runs, else to IDLE with a batch_done pulse.
REQ-031 lat_total, iter_starts and iter_ends SHALL saturate at all-ones and not wrap.
REQ-032 If the latency counter reaches TIMEOUT without k_ap_done, the block SHALL set err_timeout, drop k_ap_start, pulse batch_done and enter IDLE without updating the statistics.
REQ-033 iter_start and iter_end SHALL be counted only while busy; both strobes in the same cycle SHALL both count, leaving in-flight unchanged.
REQ-034 If iter_end arrives while in-flight==0, err_iter SHALL be set and iter_ends SHALL NOT increment.
REQ-035 max_inflight SHALL update in the same cycle the in-flight value exceeds it.
REQ-036 All outputs SHALL be registered; statistics SHALL hold their values in IDLE until the next cfg_start.

Reset
REQ-037 Assertion of ap_rst_n==0 SHALL immediately force IDLE, k_ap_start=0, busy=0, batch_done=0, all counters and flags to 0, and lat_min to all-ones, including mid-batch.
REQ-038 After deassertion, the block SHALL accept cfg_start on the first rising edge.

Verification
REQ-039 cfg_runs=3; kernel asserts ready 2 cycles after start and done at latencies 10, 7, 12 -> lat_min=7, lat_max=12, lat_total=29, run_count=3, one batch_done.
REQ-040 cfg_runs=1; ready and done in the first LAUNCH cycle -> latency 1, k_ap_start high exactly 1 cycle.
REQ-041 cfg_runs=0 -> batch_done 1 cycle after cfg_start, k_ap_start never asserted, lat_min=all-ones.
REQ-042 TIMEOUT=20 and done never arrives -> err_timeout=1 and batch_done at counter 20, run_count=0, k_ap_start=0.
REQ-043 5 iter_start pulses, then an iter_start/iter_end pair in the same cycle, then 7 iter_end pulses -> iter_starts=6, iter_ends=6, max_inflight=5, err_iter=1.
REQ-044 ap_rst_n asserted in WAIT_DONE of run 2 of 4 -> all outputs return to their reset values asynchronously, and a new batch runs correctly.
